// File: rtl/image_sdram_writer_pkg.sv
// Shared types for the image SDRAM writer: word-write entry, byte lanes, output-slot states.
package image_sdram_writer_pkg;

  localparam int unsigned SD_ADDR_W   = 25;
  localparam int unsigned BYTE_ADDR_W = 26;
  localparam int unsigned STATS_W     = 24;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  typedef struct packed {
    logic [SD_ADDR_W-1:0] addr;
    logic [15:0]          data;
    logic [1:0]           mask;
  } sdram_wr_entry_t;

  localparam int unsigned ENTRY_W = $bits(sdram_wr_entry_t);

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_REQ  = 1'b1
  } out_state_e;

  function automatic logic [15:0] lane_data(input logic lane, input logic [7:0] b);
    return (lane == LANE_HI) ? {b, 8'h00} : {8'h00, b};
  endfunction

  function automatic logic [1:0] lane_mask(input logic lane);
    return (lane == LANE_HI) ? 2'b10 : 2'b01;
  endfunction

  // Pending entry seeded by a single byte.
  function automatic sdram_wr_entry_t new_entry(input logic [SD_ADDR_W-1:0] waddr,
                                                input logic lane, input logic [7:0] b);
    sdram_wr_entry_t e;
    e.addr = waddr;
    e.data = lane_data(lane, b);
    e.mask = lane_mask(lane);
    return e;
  endfunction

endpackage

// File: rtl/image_sdram_writer_if.sv
// SDRAM write-port handshake: the writer drives req/addr/data/mask, the controller drives ready.
interface image_sdram_writer_if #(
  parameter int unsigned ADDR_W = 25
) ();
  logic              sd_wr_req;
  logic [ADDR_W-1:0] sd_addr;
  logic [15:0]       sd_data;
  logic [1:0]        sd_mask;
  logic              sd_ready;

  modport master (output sd_wr_req, sd_addr, sd_data, sd_mask, input sd_ready);
  modport slave  (input sd_wr_req, sd_addr, sd_data, sd_mask, output sd_ready);
endinterface

// File: rtl/image_sdram_writer_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is accepted only with a same-cycle pop.
module image_sdram_writer_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr_ok_c, rd_ok_c;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign pop_data = mem[rd_ptr_q];
  assign rd_ok_c  = pop & ~empty;
  assign wr_ok_c  = push & (~full | rd_ok_c);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok_c) begin
        mem[wr_ptr_q] <= push_data;
        wr_ptr_q      <= wr_ptr_q + AW'(1);
      end
      if (rd_ok_c) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_ok_c, rd_ok_c})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/image_sdram_writer.sv
// Packs loader byte writes into 16-bit masked word writes, buffers them and drains to SDRAM.
// Optional IMAGE_WRITER_STATS_EN adds a saturating word_count of completed SDRAM handshakes.
module image_sdram_writer
  import image_sdram_writer_pkg::*;
#(
  parameter int unsigned FIFO_AW = 3,
  parameter int unsigned ADDR_W  = SD_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   download_active,
  input  logic                   image_download,
  input  logic                   wr_8bit,
  input  logic [BYTE_ADDR_W-1:0] addr_8bit,
  input  logic [7:0]             data_8bit,
  image_sdram_writer_if.master   sd,
`ifdef IMAGE_WRITER_STATS_EN
  output logic [STATS_W-1:0]     word_count,
`endif
  output logic                   busy,
  output logic                   overflow
);

  sdram_wr_entry_t      pend_q, pend_d, fresh_c, merged_c, push_entry_c;
  logic                 pend_valid_q, pend_valid_d;
  logic                 accept_c, lane_c, push_c;
  logic [SD_ADDR_W-1:0] waddr_c;

  logic [ENTRY_W-1:0]   fifo_head;
  logic                 fifo_full, fifo_empty, pop_c, drop_c;

  out_state_e           state_q, state_d;
  sdram_wr_entry_t      slot_q, slot_d;
  logic                 dl_q, dl_rise_c, handshake_c;

  assign accept_c = wr_8bit & image_download;
  assign lane_c   = addr_8bit[0];
  assign waddr_c  = addr_8bit[BYTE_ADDR_W-1:1];
  assign fresh_c  = new_entry(waddr_c, lane_c, data_8bit);

  always_comb begin
    merged_c      = pend_q;
    merged_c.data = pend_q.data | lane_data(lane_c, data_8bit);
    merged_c.mask = pend_q.mask | lane_mask(lane_c);
  end

  // Byte packer: at most one push per cycle falls out of the branch structure.
  always_comb begin
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    push_c       = 1'b0;
    push_entry_c = pend_q;
    if (accept_c) begin
      if (!pend_valid_q) begin
        pend_d       = fresh_c;
        pend_valid_d = 1'b1;
      end else if ((pend_q.addr == waddr_c) && !pend_q.mask[lane_c]) begin
        if (merged_c.mask == 2'b11) begin
          push_c       = 1'b1;
          push_entry_c = merged_c;
          pend_valid_d = 1'b0;
        end else begin
          pend_d = merged_c;
        end
      end else begin
        push_c = 1'b1;
        pend_d = fresh_c;
      end
    end else if (pend_valid_q && !download_active && !wr_8bit) begin
      push_c       = 1'b1;
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  image_sdram_writer_sync_fifo #(
    .WIDTH (ENTRY_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_c),
    .push_data (push_entry_c),
    .pop       (pop_c),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign drop_c      = push_c & fifo_full & ~pop_c;
  assign handshake_c = (state_q == OUT_REQ) & sd.sd_ready;

  // Output request slot; reloading on the handshake cycle keeps requests back-to-back.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    pop_c   = 1'b0;
    case (state_q)
      OUT_IDLE: begin
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          slot_d  = sdram_wr_entry_t'(fifo_head);
          state_d = OUT_REQ;
        end
      end
      OUT_REQ: begin
        if (sd.sd_ready) begin
          if (!fifo_empty) begin
            pop_c  = 1'b1;
            slot_d = sdram_wr_entry_t'(fifo_head);
          end else begin
            state_d = OUT_IDLE;
          end
        end
      end
      default: state_d = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= OUT_IDLE;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  assign sd.sd_wr_req = (state_q == OUT_REQ);
  assign sd.sd_addr   = ADDR_W'(slot_q.addr);
  assign sd.sd_data   = slot_q.data;
  assign sd.sd_mask   = slot_q.mask;
  assign busy         = pend_valid_q | ~fifo_empty | (state_q == OUT_REQ);

  assign dl_rise_c = download_active & ~dl_q;

  // Sticky drop flag; a new download session clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_q     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      dl_q <= download_active;
      if (drop_c)         overflow <= 1'b1;
      else if (dl_rise_c) overflow <= 1'b0;
    end
  end

`ifdef IMAGE_WRITER_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_count <= '0;
    end else if (dl_rise_c) begin
      word_count <= '0;
    end else if (handshake_c && (word_count != {STATS_W{1'b1}})) begin
      word_count <= word_count + STATS_W'(1);
    end
  end
`else
  logic unused_handshake;
  assign unused_handshake = handshake_c;
`endif

endmodule
